// File: rtl/parity_pkg.sv
// Shared types and helpers for the streaming parity frame generator.
// The FSM enum is used only when PARITY_LRC_EN is defined.
package parity_pkg;

  // Widest word par_of() can reduce; narrower words are zero-extended, which leaves parity unchanged.
  localparam int unsigned PAR_MAX_W = 256;

  typedef enum logic [0:0] {
    ST_DATA,
    ST_TRAIL
  } state_e;

  function automatic logic par_of(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a DATA_W-bit word, inverted when ODD is set.
// DATA_W must not exceed PAR_MAX_W.
module parity_calc
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  logic [PAR_MAX_W-1:0] data_ext;

  assign data_ext = PAR_MAX_W'(data_i);
  assign par_o    = par_of(data_ext, ODD);

endmodule

// File: rtl/parity_frame_gen.sv
// Streaming per-word parity generator with frame tracking and a completed-frame counter.
// Define PARITY_LRC_EN to append an LRC trailer beat after each frame.
module parity_frame_gen
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_par_o,
  output logic              m_last_o,
  output logic              m_trailer_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_par_q, m_par_d;
  logic              m_last_q, m_last_d;
  logic              m_trailer_q, m_trailer_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic out_free, in_acc, out_xfer, in_par;
  logic trail_load, lrc_par;
  logic [DATA_W-1:0] lrc_q;

  assign out_free = !m_valid_q || m_ready_i;
  assign in_acc   = s_valid_i && s_ready_o;
  assign out_xfer = m_valid_q && m_ready_i;

  parity_calc #(
    .DATA_W(DATA_W),
    .ODD   (ODD)
  ) u_in_par (
    .data_i(s_data_i),
    .par_o (in_par)
  );

`ifdef PARITY_LRC_EN
  localparam bit LrcEn = 1'b1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] lrc_d;

  parity_calc #(
    .DATA_W(DATA_W),
    .ODD   (ODD)
  ) u_lrc_par (
    .data_i(lrc_q),
    .par_o (lrc_par)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_DATA;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DATA:  if (in_acc && s_last_i) state_d = ST_TRAIL;
      ST_TRAIL: if (out_free) state_d = ST_DATA;
      default:  state_d = ST_DATA;
    endcase
  end

  always_comb begin
    s_ready_o  = !rst_i && out_free && (state_q == ST_DATA);
    trail_load = (state_q == ST_TRAIL) && out_free;
  end

  // Trailer load clears the accumulator for the next frame.
  always_comb begin
    lrc_d = lrc_q;
    if (trail_load) begin
      lrc_d = '0;
    end else if (in_acc) begin
      lrc_d = lrc_q ^ s_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lrc_q <= '0;
    end else begin
      lrc_q <= lrc_d;
    end
  end
`else
  localparam bit LrcEn = 1'b0;

  assign trail_load = 1'b0;
  assign lrc_par    = 1'b0;
  assign lrc_q      = '0;

  always_comb begin
    s_ready_o = !rst_i && out_free;
  end
`endif

  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_par_d     = m_par_q;
    m_last_d    = m_last_q;
    m_trailer_d = m_trailer_q;
    if (in_acc) begin
      m_valid_d   = 1'b1;
      m_data_d    = s_data_i;
      m_par_d     = in_par;
      m_last_d    = LrcEn ? 1'b0 : s_last_i;
      m_trailer_d = 1'b0;
    end else if (trail_load) begin
      m_valid_d   = 1'b1;
      m_data_d    = lrc_q;
      m_par_d     = lrc_par;
      m_last_d    = 1'b1;
      m_trailer_d = 1'b1;
    end else if (out_free) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_xfer && m_last_q) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_par_q     <= 1'b0;
      m_last_q    <= 1'b0;
      m_trailer_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_par_q     <= m_par_d;
      m_last_q    <= m_last_d;
      m_trailer_q <= m_trailer_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_valid_o   = m_valid_q;
  assign m_data_o    = m_data_q;
  assign m_par_o     = m_par_q;
  assign m_last_o    = m_last_q;
  assign m_trailer_o = m_trailer_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
